// File: rtl/fsm_job_sched.sv
// Round-robin scheduler sharing one job engine among NREQ requesters.
// A watchdog aborts a hung engine and flags the owning requester.
module fsm_job_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_en,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         nack,
  output logic [NREQ-1:0]         err,
  input  logic [NREQ-1:0]         err_clr,
  output logic                    eng_go,
  output logic                    eng_rst,
  input  logic [1:0]              eng_state,
  input  logic                    eng_done,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [CNTW-1:0]         job_count
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_ACK,
    S_RECOVER
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   win;
  logic [GW-1:0]   cand;
  logic            found;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gmask;
  logic [TW-1:0]   timer;

  assign gmask = NREQ'(1) << grant_id;

  // Search starts just after the last winner, wrapping at NREQ-1.
  always_comb begin
    elig  = req & req_en;
    win   = '0;
    found = 1'b0;
    cand  = last_grant;
    for (int j = 0; j < NREQ; j++) begin
      cand = (cand == GLAST) ? '0 : cand + GW'(1);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (found && eng_state == 2'd0) state_n = S_ISSUE;
      end
      S_ISSUE: state_n = S_BUSY;
      S_BUSY: begin
        if (eng_done)           state_n = S_ACK;
        else if (timer == TMAX) state_n = S_RECOVER;
      end
      S_ACK:     state_n = S_IDLE;
      S_RECOVER: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_go     <= 1'b0;
      eng_rst    <= 1'b0;
      busy       <= 1'b0;
      ack        <= '0;
      nack       <= '0;
      err        <= '0;
      grant_id   <= '0;
      job_count  <= '0;
      last_grant <= GLAST;
      timer      <= '0;
    end else begin
      eng_go  <= (state_n == S_ISSUE);
      eng_rst <= (state_n == S_RECOVER);
      busy    <= (state_n != S_IDLE);
      ack     <= (state_n == S_ACK) ? gmask : '0;
      nack    <= (state_n == S_RECOVER) ? gmask : '0;
      err     <= (err & ~err_clr) |
                 ((state_n == S_RECOVER) ? gmask : '0);
      if (state == S_IDLE && state_n == S_ISSUE)
        grant_id <= win;
      if (state_n == S_ACK)
        job_count <= job_count + CNTW'(1);
      if (state_n == S_ACK || state_n == S_RECOVER)
        last_grant <= grant_id;
      if (state == S_ISSUE)
        timer <= '0;
      else if (state == S_BUSY)
        timer <= timer + TW'(1);
    end
  end

endmodule
